// File: rtl/printer_buffer.sv
// Buffered printer: latches PD/TR handshakes into a small FIFO and drains it at
// PRINT_CYCLES per byte. Optional sticky overrun flag OVR with `PRINTER_OVERRUN_EN.
module printer_buffer #(
  parameter int DEPTH        = 4,
  parameter int PRINT_CYCLES = 13
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     TR,
  input  logic [7:0]               PD,
  output logic                     RDY,
  output logic [7:0]               data,
  output logic                     data_valid,
  output logic [$clog2(DEPTH):0]   count
`ifdef PRINTER_OVERRUN_EN
  ,
  output logic                     OVR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PRINT_CYCLES + 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FULL} rstate_t;
  typedef enum logic {P_IDLE, P_PRINT} pstate_t;

  rstate_t        r_rstate, w_rnext;
  pstate_t        r_pstate, w_pnext;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic [PW-1:0]  r_pcnt;
  logic [7:0]     r_preg, r_data;
  logic           r_rdy, r_dv;
  logic           w_push, w_pop, w_done;

  // A push is only ever taken on the R_IDLE->R_WAIT edge; R_IDLE implies free space.
  assign w_push      = (r_rstate == R_IDLE) && TR;
  assign w_pop       = (r_pstate == P_IDLE) && (r_count != '0);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (TR) w_rnext = R_WAIT;
      R_WAIT:  if (!TR) w_rnext = (w_count_nxt < CW'(DEPTH)) ? R_IDLE : R_FULL;
      R_FULL:  if (w_pop) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_pnext = r_pstate;
    w_done  = 1'b0;
    case (r_pstate)
      P_IDLE:  if (w_pop) w_pnext = P_PRINT;
      P_PRINT: begin
        if (r_pcnt == '0) begin
          w_done  = 1'b1;
          w_pnext = P_IDLE;
        end
      end
      default: w_pnext = P_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rstate <= R_IDLE;
      r_pstate <= P_IDLE;
      r_rdy    <= 1'b1;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_pcnt   <= '0;
      r_data   <= 8'h00;
      r_dv     <= 1'b0;
    end else begin
      r_rstate <= w_rnext;
      r_pstate <= w_pnext;
      r_rdy    <= (w_rnext == R_IDLE);
      r_count  <= w_count_nxt;
      r_dv     <= w_done;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_done) r_data <= r_preg;
      if (w_pop)
        r_pcnt <= PW'(PRINT_CYCLES - 1);
      else if (r_pstate == P_PRINT && r_pcnt != '0)
        r_pcnt <= r_pcnt - PW'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= PD;
    if (w_pop)  r_preg <= r_mem[r_rptr];
  end

`ifdef PRINTER_OVERRUN_EN
  logic r_tr_d, r_ovr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tr_d <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_tr_d <= TR;
      if (r_rstate == R_FULL && TR && !r_tr_d) r_ovr <= 1'b1;
    end
  end

  assign OVR = r_ovr;
`endif

  assign RDY        = r_rdy;
  assign data       = r_data;
  assign data_valid = r_dv;
  assign count      = r_count;

endmodule

// File: tb/tb_printer_buffer.sv
// Scoreboard bench for printer_buffer: bytes are queued when handed over and
// compared when data_valid fires. Define PRINTER_OVERRUN_EN to cover OVR.
module tb_printer_buffer;
  localparam int DEPTH = 4;
  localparam int PC    = 13;

  logic                    CLK = 1'b0;
  logic                    RST, TR;
  logic [7:0]              PD;
  logic                    RDY, data_valid;
  logic [7:0]              data;
  logic [$clog2(DEPTH):0]  count;
`ifdef PRINTER_OVERRUN_EN
  logic                    OVR;
`endif

  printer_buffer #(.DEPTH(DEPTH), .PRINT_CYCLES(PC)) dut (
    .CLK(CLK), .RST(RST), .TR(TR), .PD(PD), .RDY(RDY),
    .data(data), .data_valid(data_valid), .count(count)
`ifdef PRINTER_OVERRUN_EN
    , .OVR(OVR)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_dv = -1;
  int          cmax = 0;
  bit          spc_en = 1'b0;
  logic [7:0]  q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (int'(count) > cmax) cmax = int'(count);
    if (data_valid === 1'b1) begin
      if (q.size() == 0) check("dv_unexpected", {24'h0, data}, 32'hFFFF_FFFF);
      else check("print_data", data, q.pop_front());
      if (spc_en && last_dv >= 0) check("dv_spacing", cyc - last_dv, PC + 1);
      last_dv = cyc;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    while (RDY !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (RDY !== 1'b1) check("rdy_timeout", RDY, 1);
    TR = 1'b1;
    PD = b;
    q.push_back(b);
    tick();
    check("capture_rdy", RDY, 0);
    TR = 1'b0;
    tick();
  endtask

  task automatic wait_drain;
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    tick();
  endtask

  initial begin
    RST = 1'b1;
    TR  = 1'b1;
    PD  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy", RDY, 1);
      check("rst_data", data, 8'h00);
      check("rst_dv", data_valid, 0);
      check("rst_count", count, 0);
    end
    RST = 1'b0;
    TR  = 1'b0;
    tick();
    check("post_rst_rdy", RDY, 1);
    check("post_rst_data", data, 8'h00);
    check("post_rst_count", count, 0);
`ifdef PRINTER_OVERRUN_EN
    check("post_rst_ovr", OVR, 0);
`endif

    // Single byte, TR held for two cycles; exact print latency.
    TR = 1'b1;
    PD = 8'hA5;
    q.push_back(8'hA5);
    tick();
    check("single_rdy_lo", RDY, 0);
    check("single_count1", count, 1);
    tick();
    check("single_count0", count, 0);
    check("single_rdy_held", RDY, 0);
    TR = 1'b0;
    for (int i = 2; i <= PC + 1; i++) begin
      tick();
      check("single_latency", data_valid, (i == PC + 1) ? 1 : 0);
      if (i == 2) check("single_rdy_back", RDY, 1);
    end
    check("single_data", data, 8'hA5);
    tick();
    check("dv_one_cycle", data_valid, 0);
    check("data_holds", data, 8'hA5);

    // Back-to-back bytes.
    cmax = 0;
    last_dv = -1;
    spc_en = 1'b1;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_drain();
    spc_en = 1'b0;
    check("b2b_count_max", cmax, 2);
    check("b2b_last_data", data, 8'h03);

    // Fill to full.
    cmax = 0;
    last_dv = -1;
    spc_en = 1'b1;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    check("full_count", count, DEPTH);
    check("full_rdy", RDY, 0);
`ifdef PRINTER_OVERRUN_EN
    TR = 1'b1;
    PD = 8'hEE;
    tick();
    TR = 1'b0;
    check("ovr_set", OVR, 1);
`endif
    tick();
    check("full_rdy_stuck", RDY, 0);
    check("full_count_held", count, DEPTH);
    wait_drain();
    spc_en = 1'b0;
    check("fill_count_max", cmax, DEPTH);
    check("fill_count_empty", count, 0);
`ifdef PRINTER_OVERRUN_EN
    check("ovr_sticky", OVR, 1);
`endif

    // Reset in the middle of a print.
    send(8'h5A);
    repeat (4) tick();
    RST = 1'b1;
    q.delete();
    tick();
    check("midrst_data", data, 8'h00);
    check("midrst_dv", data_valid, 0);
    check("midrst_count", count, 0);
`ifdef PRINTER_OVERRUN_EN
    check("ovr_cleared", OVR, 0);
`endif
    RST = 1'b0;
    repeat (PC + 5) tick();
    check("midrst_no_print", data, 8'h00);
    send(8'h33);
    wait_drain();
    check("after_rst_data", data, 8'h33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
